// File: rtl/keypad_pkg.sv
// Shared types and constants for the hex keypad entry block.
// Key layout, column decode and row decode helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } kp_state_t;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  // Indexed [row][col], row 0 at the top, col 0 at the left.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  // Active-low column drive for one column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    col_drive = ~(4'b0001 << idx);
  endfunction

  // Index of the single low row bit; only used on one-hot-low patterns.
  function automatic logic [1:0] row_index(input logic [3:0] r);
    unique case (r)
      4'b1110: row_index = 2'd0;
      4'b1101: row_index = 2'd1;
      4'b1011: row_index = 2'd2;
      4'b0111: row_index = 2'd3;
      default: row_index = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Reset value is a parameter so idle-high inputs stay idle.
module sync_2ff #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with debounce and a 32-bit
// digit entry register feeding the display and ALU.
module hex_keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic [31:0] number,
  output logic        load,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES);

  logic [3:0]    row_s;
  kp_state_t     state;
  logic [1:0]    col_idx;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] db_cnt;
  logic [3:0]    row_lat;
  logic [1:0]    row_idx;
  logic [3:0]    code_new;

  sync_2ff #(
    .WIDTH     (4),
    .RESET_VAL (ROW_IDLE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_s)
  );

  assign code_new = KEY_MAP[row_idx][col_idx];

  // Scan/debounce state machine with registered outputs and entry register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      col       <= 4'b1110;
      scan_cnt  <= '0;
      db_cnt    <= '0;
      row_lat   <= ROW_IDLE;
      row_idx   <= 2'd0;
      number    <= '0;
      load      <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      load      <= 1'b0;
      key_valid <= 1'b0;
      if (clr) begin
        number <= '0;
        load   <= 1'b1;
      end
      unique case (state)
        SCAN: begin
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if ($onehot(~row_s)) begin
              row_lat <= row_s;
              row_idx <= row_index(row_s);
              db_cnt  <= '0;
              state   <= PRESS_DB;
            end else begin
              col_idx <= col_idx + 2'd1;
              col     <= col_drive(col_idx + 2'd1);
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        PRESS_DB: begin
          if (row_s != row_lat) begin
            db_cnt   <= '0;
            scan_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            col      <= col_drive(col_idx + 2'd1);
            state    <= SCAN;
          end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            state  <= HELD;
            if (!clr) begin
              key_code  <= code_new;
              number    <= {number[27:0], code_new};
              load      <= 1'b1;
              key_valid <= 1'b1;
            end
          end else if (db_cnt != DB_MAX) begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        HELD: begin
          if (row_s == ROW_IDLE) begin
            db_cnt <= '0;
            state  <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (row_s != ROW_IDLE) begin
            db_cnt <= '0;
            state  <= HELD;
          end else if (db_cnt == DB_LAST) begin
            db_cnt   <= '0;
            scan_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            col      <= col_drive(col_idx + 2'd1);
            state    <= SCAN;
          end else if (db_cnt != DB_MAX) begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Self-checking bench for hex_keypad_entry with a keypad
// matrix model, directed vector table and corner sequences.
module tb_hex_keypad_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [31:0] number;
  logic        load;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] pressed;

  int n_checks = 0;
  int n_fail   = 0;
  int kv_cnt   = 0;
  int ld_cnt   = 0;

  typedef struct {
    int          r;
    int          c;
    logic [3:0]  code;
    logic [31:0] num;
  } vec_t;

  vec_t tbl [13];
  logic [3:0] col_exp [4];

  always #5 clk = ~clk;

  hex_keypad_entry #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .clr       (clr),
    .col       (col),
    .number    (number),
    .load      (load),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // Pulse counters.
  always @(posedge clk) begin
    if (key_valid) kv_cnt++;
    if (load) ld_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input int r, input int c);
    int base;
    int i;
    base = kv_cnt;
    pressed[r*4+c] = 1'b1;
    i = 0;
    while (i < 100 && kv_cnt == base) begin
      @(negedge clk);
      i++;
    end
    if (kv_cnt == base) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: key r%0d c%0d not accepted", r, c);
    end
    cycles(10);
    pressed[r*4+c] = 1'b0;
    cycles(30);
  endtask

  initial begin
    int bkv;
    int bld;
    int chg;
    logic [3:0] pc;

    col_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    tbl[0]  = '{0, 0, 4'h1, 32'h0000_0001};
    tbl[1]  = '{0, 1, 4'h2, 32'h0000_0012};
    tbl[2]  = '{0, 2, 4'h3, 32'h0000_0123};
    tbl[3]  = '{0, 3, 4'hA, 32'h0000_123A};
    tbl[4]  = '{1, 0, 4'h4, 32'h0001_23A4};
    tbl[5]  = '{1, 1, 4'h5, 32'h0012_3A45};
    tbl[6]  = '{1, 2, 4'h6, 32'h0123_A456};
    tbl[7]  = '{1, 3, 4'hB, 32'h123A_456B};
    tbl[8]  = '{2, 0, 4'h7, 32'h23A4_56B7};
    tbl[9]  = '{3, 0, 4'h0, 32'h3A45_6B70};
    tbl[10] = '{3, 1, 4'hF, 32'hA456_B70F};
    tbl[11] = '{3, 2, 4'hE, 32'h456B_70FE};
    tbl[12] = '{3, 3, 4'hD, 32'h56B7_0FED};

    rst = 1'b1;
    clr = 1'b0;
    pressed = '0;
    cycles(3);
    rst = 1'b0;

    // Reset values and idle column rotation.
    check("rst_col", col, 4'b1110);
    check("rst_number", number, 0);
    check("rst_load", load, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    bld = ld_cnt;
    for (int k = 0; k < 20; k++) begin
      check("idle_col", col, col_exp[(k/4)%4]);
      cycles(1);
    end
    check("idle_load_cnt", ld_cnt - bld, 0);

    // Single press, held 40 cycles.
    bkv = kv_cnt;
    bld = ld_cnt;
    pressed[1*4+2] = 1'b1;
    cycles(40);
    pressed = '0;
    cycles(30);
    check("single_kv_cnt", kv_cnt - bkv, 1);
    check("single_ld_cnt", ld_cnt - bld, 1);
    check("single_code", key_code, 4'h6);
    check("single_number", number, 32'h6);

    // One-cycle clear.
    bld = ld_cnt;
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    cycles(1);
    check("clr_number", number, 0);
    check("clr_ld_cnt", ld_cnt - bld, 1);

    // Digit entry table.
    for (int i = 0; i < 13; i++) begin
      bkv = kv_cnt;
      bld = ld_cnt;
      tap(tbl[i].r, tbl[i].c);
      check("tbl_kv_cnt", kv_cnt - bkv, 1);
      check("tbl_ld_cnt", ld_cnt - bld, 1);
      check("tbl_code", key_code, tbl[i].code);
      check("tbl_number", number, tbl[i].num);
    end

    // Clear held for three cycles.
    bld = ld_cnt;
    clr = 1'b1;
    cycles(3);
    clr = 1'b0;
    cycles(1);
    check("clr3_ld_cnt", ld_cnt - bld, 3);
    check("clr3_number", number, 0);

    // Bouncing contact, then stable.
    bkv = kv_cnt;
    for (int i = 0; i < 10; i++) begin
      pressed[2*4+3] = (i % 2 == 0);
      cycles(3);
    end
    pressed[2*4+3] = 1'b1;
    cycles(40);
    pressed = '0;
    cycles(30);
    check("bounce_kv_cnt", kv_cnt - bkv, 1);
    check("bounce_code", key_code, 4'hC);

    // Short glitch.
    bkv = kv_cnt;
    pressed[3*4+0] = 1'b1;
    cycles(5);
    pressed = '0;
    cycles(40);
    check("glitch_kv_cnt", kv_cnt - bkv, 0);

    // Two rows low in one column.
    bkv = kv_cnt;
    pressed[0*4+1] = 1'b1;
    pressed[2*4+1] = 1'b1;
    chg = 0;
    pc = col;
    for (int i = 0; i < 60; i++) begin
      cycles(1);
      if (col != pc) chg++;
      pc = col;
    end
    pressed = '0;
    cycles(30);
    check("tworow_kv_cnt", kv_cnt - bkv, 0);
    check("tworow_scanning", chg >= 3, 1);

    // Clear coinciding with acceptance of key '1' (accepted 12 edges after reset).
    rst = 1'b1;
    pressed[0] = 1'b1;
    cycles(2);
    rst = 1'b0;
    bkv = kv_cnt;
    bld = ld_cnt;
    cycles(11);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    check("coin_number", number, 0);
    check("coin_load", load, 1);
    check("coin_key_valid", key_valid, 0);
    check("coin_key_code", key_code, 0);
    cycles(20);
    check("coin_kv_cnt", kv_cnt - bkv, 0);
    check("coin_ld_cnt", ld_cnt - bld, 1);
    pressed = '0;
    cycles(30);

    // Reset during press debounce of key '5' on column 1.
    rst = 1'b1;
    pressed[1*4+1] = 1'b1;
    cycles(2);
    rst = 1'b0;
    bkv = kv_cnt;
    bld = ld_cnt;
    cycles(12);
    check("rstdb_col_before", col, 4'b1101);
    rst = 1'b1;
    #1;
    check("rstdb_col", col, 4'b1110);
    check("rstdb_number", number, 0);
    check("rstdb_load", load, 0);
    check("rstdb_key_valid", key_valid, 0);
    check("rstdb_key_code", key_code, 0);
    pressed = '0;
    cycles(2);
    rst = 1'b0;
    cycles(30);
    check("rstdb_kv_cnt", kv_cnt - bkv, 0);
    check("rstdb_ld_cnt", ld_cnt - bld, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_keypad_entry.md
# hex_keypad_entry

Scans a 4x4 hex keypad (Pmod KYPD layout), debounces key presses and shifts each accepted hex digit into a 32-bit entry register. Each new digit enters at the LSB. The block is the input-side counterpart to the seven-segment display driver: its `number` and `load` outputs connect directly to the driver's `number` and `load` inputs, and `number` also feeds the ALU operand path.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven before the scan advances.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples needed to accept a press or a release.
- `clk` (in, 1): system clock, 100 MHz.
- `rst` (in, 1): reset. One clock; reset is asynchronous and active-high.
- `row` (in, 4): keypad rows, active low, externally pulled up. Asynchronous to `clk`.
- `clr` (in, 1): synchronous clear of the entry register. Level-sampled every cycle.
- `col` (out, 4): keypad column drive, active low, exactly one bit low at all times.
- `number` (out, 32): entry register.
- `load` (out, 1): one-cycle pulse whenever `number` changes.
- `key_valid` (out, 1): one-cycle pulse when a key is accepted.
- `key_code` (out, 4): hex value of the last accepted key. Held between presses.

## Operation
- `row` passes through a 2-flop synchronizer. All logic uses the synchronized value `row_s`.
- Key map, indexed by row r (top to bottom) and column c (left to right):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- The state machine has four states: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN:
  - Drives `col` low on index `col_idx` and counts `SCAN_DIV` cycles.
  - On the last cycle of the period, samples `row_s`.
  - If exactly one row bit is low: latches that row and `col_idx`, then goes to PRESS_DB with `col_idx` unchanged.
  - Otherwise (no row low, or two or more low): `col_idx` increments, wrapping 3 to 0, and the state stays SCAN.
- PRESS_DB:
  - Holds the column and counts consecutive cycles where `row_s` equals the latched pattern.
  - Any mismatch returns to SCAN and advances the column.
  - When the count reaches `DEBOUNCE_CYCLES`, the key is accepted and the state goes to HELD.
- Key acceptance, all in one registered edge:
  - `key_code` takes the mapped value.
  - `number` becomes `{number[27:0], key_code}`.
  - `key_valid` and `load` are high for exactly one cycle.
- HELD: holds the column and waits until `row_s` is 4'b1111, then goes to RELEASE_DB.
- RELEASE_DB:
  - Counts consecutive all-high cycles.
  - Any low row bit returns to HELD.
  - When the count reaches `DEBOUNCE_CYCLES`, returns to SCAN and advances the column.
- A held key never repeats.
- `clr` high: `number` becomes 0 and `load` pulses for one cycle. The state machine is unaffected.
  - If `clr` and key acceptance fall in the same cycle, `clr` wins: `number` becomes 0, `load` pulses, `key_valid` stays 0, `key_code` is unchanged, and the state still moves to HELD.
  - `clr` held high for N cycles gives N `load` pulses. This is harmless because the value is constant.
- Width rules:
  - Shifting drops `number[31:28]`; entering a ninth digit discards the oldest.
  - The scan counter is sized `$clog2(SCAN_DIV)`.
  - The debounce counter is sized `$clog2(DEBOUNCE_CYCLES+1)` and saturates; it does not wrap.

## Timing
- Reset values:
  - `col` = 4'b1110
  - `number` = 0
  - `load` = 0
  - `key_valid` = 0
  - `key_code` = 0
  - state = SCAN, `col_idx` = 0, both counters = 0, synchronizer flops = 4'b1111.
- Reset asserted mid-operation aborts any debounce immediately; no pulse is emitted.
- The input synchronizer adds 2 cycles of latency.
- The column changes on the edge after the sample cycle. Rows must settle within `SCAN_DIV` minus 3 cycles.
- Press-to-`key_valid` latency: 2 (synchronizer) + time to reach the sample point + `DEBOUNCE_CYCLES` cycles.
- `load` and the new `number` appear on the same edge, so the display driver captures the new value on the following edge.
- All outputs are registered; there is no combinational path from `row` to any output.

## Structure
- Package `keypad_pkg` contains:
  - enum `kp_state_t` {SCAN, PRESS_DB, HELD, RELEASE_DB};
  - constant `KEY_MAP[4][4]` of 4-bit values;
  - the all-released constant `ROW_IDLE` = 4'b1111.
- Sub-module `sync_2ff` (parameterized width): the row synchronizer, reusable for the board's push-buttons.
- All other logic (scan counter, state machine, debounce counter, entry register) stays in a single module.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE_CYCLES`=8.
- Reset, no key: `col` cycles 1110 → 1101 → 1011 → 0111 → 1110, 4 cycles each; `number`=0; `load`=0.
- Single press, row1/col2 held for 40 cycles, then released:
  - exactly one `key_valid`, with `key_code`=4'h6;
  - `number`=32'h0000_0006 with one `load` pulse;
  - no repeat while held.
- Bounce: row toggles every 3 cycles for 30 cycles, then is stable for 20 → one acceptance only. A 5-cycle glitch → no acceptance.
- Nine keys in sequence, 1 2 3 A 4 5 6 B 7 → `number`=32'h23A4_56B7 after the last key, with 9 `load` pulses.
- Two rows low in the same column → no acceptance; scanning continues.
- Boundary cases:
  - `clr` on the same cycle as acceptance → `number`=0, one `load`, no `key_valid`.
  - `rst` during PRESS_DB → outputs return to their reset values and no pulse appears.
